// File: rtl/bram_dp_clr_if.sv
// Bus bundle for bram_dp_clr: clear-engine handshake plus the write and read ports.
// The master side drives commands, addresses and write data; the slave side is the RAM.
interface bram_dp_clr_if #(
    parameter int DW = 18,
    parameter int AW = 9
);
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_din;
    logic [DW-1:0] wr_dout;
    logic [DW-1:0] rd_dout;

    modport master (
        output clr_start, wr_en, wr_addr, rd_addr, wr_din,
        input  clr_busy, clr_done, wr_dout, rd_dout
    );

    modport slave (
        input  clr_start, wr_en, wr_addr, rd_addr, wr_din,
        output clr_busy, clr_done, wr_dout, rd_dout
    );
endinterface

// File: rtl/bram_dp_clr.sv
// Simple-dual-port block RAM with registered addresses and a one-word-per-cycle clear engine.
// Define BRAM_OUTREG_EN to add the output pipeline register (read latency 2).
module bram_dp_clr #(
    parameter int DW         = 18,
    parameter int AW         = 9,
    parameter int DEPTH      = 512,
    parameter int CLR_ON_RST = 0
) (
    input logic          clk,
    input logic          rst,
    bram_dp_clr_if.slave bus
);
    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          rst_d;
    logic          auto_start;
    logic [AW-1:0] reg_wra, reg_rda;
    logic [DW-1:0] wr_q, rd_q;
    logic [DW-1:0] mem [DEPTH];

    // rst_d remembers that the previous edge was in reset, giving the auto-clear trigger.
    assign auto_start = (CLR_ON_RST != 0) && rst_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rst_d   <= 1'b1;
            reg_wra <= '0;
            reg_rda <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rst_d   <= 1'b0;
            reg_wra <= bus.wr_addr;
            reg_rda <= bus.rd_addr;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_start || auto_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the array has no reset branch; resetting storage would prevent block RAM mapping.
    // A reset during CLEAR suppresses that edge's sweep write so the abort is immediate.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            if (!rst) mem[cnt] <= '0;
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W)) begin
            mem[bus.wr_addr] <= bus.wr_din;
        end
    end

    assign wr_q = ({1'b0, reg_wra} < DEPTH_W) ? mem[reg_wra] : '0;
    assign rd_q = ({1'b0, reg_rda} < DEPTH_W) ? mem[reg_rda] : '0;

`ifdef BRAM_OUTREG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wr_dout <= '0;
            bus.rd_dout <= '0;
        end else begin
            bus.wr_dout <= wr_q;
            bus.rd_dout <= rd_q;
        end
    end
`else
    assign bus.wr_dout = wr_q;
    assign bus.rd_dout = rd_q;
`endif

    assign bus.clr_busy = (state == CLEAR);
    assign bus.clr_done = (state == CLEAR) && (cnt == LAST);
endmodule

// File: tb/tb_bram_dp_clr.sv
// Directed bench for bram_dp_clr: a 512-word instance and a 300-word auto-clear instance.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bram_dp_clr;
`ifdef BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    bram_dp_clr_if #(.DW(18), .AW(9)) a ();
    bram_dp_clr_if #(.DW(18), .AW(9)) b ();

    bram_dp_clr #(.DW(18), .AW(9), .DEPTH(512), .CLR_ON_RST(0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    bram_dp_clr #(.DW(18), .AW(9), .DEPTH(300), .CLR_ON_RST(1)) u_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_wr(input bit on_b, input bit en, input logic [8:0] addr, input logic [17:0] data);
        if (on_b) begin
            b.wr_en = en; b.wr_addr = addr; b.wr_din = data;
        end else begin
            a.wr_en = en; a.wr_addr = addr; a.wr_din = data;
        end
    endtask

    task automatic set_rd(input bit on_b, input logic [8:0] addr);
        if (on_b) b.rd_addr = addr;
        else      a.rd_addr = addr;
    endtask

    task automatic set_start(input bit on_b, input bit v);
        if (on_b) b.clr_start = v;
        else      a.clr_start = v;
    endtask

    task automatic wr(input bit on_b, input logic [8:0] addr, input logic [17:0] data);
        set_wr(on_b, 1'b1, addr, data);
        @(negedge clk);
        set_wr(on_b, 1'b0, addr, data);
    endtask

    task automatic rd(input bit on_b, input logic [8:0] addr, output logic [17:0] data);
        set_rd(on_b, addr);
        repeat (LAT) @(negedge clk);
        data = on_b ? b.rd_dout : a.rd_dout;
    endtask

    task automatic fill(input bit on_b, input int n, input logic [17:0] value);
        for (int i = 0; i < n; i++) begin
            set_wr(on_b, 1'b1, i[8:0], value);
            @(negedge clk);
        end
        set_wr(on_b, 1'b0, '0, '0);
    endtask

    task automatic count_bad(input bit on_b, input int lo, input int hi, input logic [17:0] exp,
                             output int bad);
        logic [17:0] d;
        bad = 0;
        for (int i = lo; i <= hi; i++) begin
            rd(on_b, i[8:0], d);
            if (d !== exp) bad++;
        end
    endtask

    task automatic pulse_start(input bit on_b);
        set_start(on_b, 1'b1);
        @(negedge clk);
        set_start(on_b, 1'b0);
    endtask

    // Called while b is busy; counts busy cycles and done pulses until busy falls.
    task automatic sweep_b(output int busy_n, output int done_n, output bit to);
        busy_n = 0; done_n = 0; to = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (b.clr_done) done_n++;
            if (b.clr_busy) busy_n++;
            else begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [17:0] d;
        int          bad;
        int          busy_n, done_n, done_idx;
        bit          to;

        a.clr_start = 1'b0; a.wr_en = 1'b0; a.wr_addr = '0; a.rd_addr = '0; a.wr_din = '0;
        b.clr_start = 1'b0; b.wr_en = 1'b0; b.wr_addr = '0; b.rd_addr = '0; b.wr_din = '0;
        rst = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", a.clr_busy, 0);
        check("rst_done", a.clr_done, 0);
`ifdef BRAM_OUTREG_EN
        check("rst_rd_dout", a.rd_dout, 0);
        check("rst_wr_dout", a.wr_dout, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_auto_clear", a.clr_busy, 0);

        // Basic latency: the old address is still visible on the cycle rd_addr changes.
        wr(0, 9'd8, 18'h00055);
        wr(0, 9'd7, 18'h2A5F3);
        rd(0, 9'd8, d);
        check("rd_addr8", d, 18'h00055);
        set_rd(0, 9'd7);
        check("rd_latency_hold", a.rd_dout, 18'h00055);
        repeat (LAT) @(negedge clk);
        check("rd_addr7", a.rd_dout, 18'h2A5F3);
        check("wr_readback7", a.wr_dout, 18'h2A5F3);

        // Collision: same-edge write and read of address 100 returns the new word.
        wr(0, 9'd100, 18'h3ABCD);
        rd(0, 9'd100, d);
        check("coll_old", d, 18'h3ABCD);
        set_wr(0, 1'b1, 9'd100, 18'h00011);
        set_rd(0, 9'd100);
        @(negedge clk);
        set_wr(0, 1'b0, 9'd100, 18'h00011);
        repeat (LAT - 1) @(negedge clk);
        check("coll_rd_dout", a.rd_dout, 18'h00011);
        check("coll_wr_dout", a.wr_dout, 18'h00011);

        // Full sweep with a stray write at cycle 10 and a re-start at cycle 100.
        fill(0, 512, 18'h3FFFF);
        rd(0, 9'd300, d);
        check("fill300", d, 18'h3FFFF);
        pulse_start(0);
        check("busy_first", a.clr_busy, 1);
        busy_n = 0; done_n = 0; done_idx = -1; to = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (a.clr_busy) begin
                if (a.clr_done) begin
                    done_n++;
                    done_idx = busy_n;
                end
                if (busy_n == 10) set_wr(0, 1'b1, 9'd5, 18'h15555);
                else              set_wr(0, 1'b0, 9'd5, 18'h0);
                set_start(0, busy_n == 100);
                busy_n++;
            end else begin
                if (a.clr_done) done_n++;
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        set_wr(0, 1'b0, '0, '0);
        set_start(0, 1'b0);
        check("sweep_timeout", to, 0);
        check("sweep_busy_cycles", busy_n, 512);
        check("sweep_done_pulses", done_n, 1);
        check("sweep_done_last", done_idx, 511);
        count_bad(0, 0, 511, 18'h0, bad);
        check("clear_all_zero", bad, 0);
        rd(0, 9'd5, d);
        check("wr_during_clear", d, 18'h0);

        // Reset at sweep cycle 200: addresses below 200 cleared, the rest untouched.
        fill(0, 512, 18'h3FFFF);
        pulse_start(0);
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_busy", a.clr_busy, 0);
        check("rst_abort_done", a.clr_done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_restart", a.clr_busy, 0);
        count_bad(0, 0, 199, 18'h0, bad);
        check("partial_zero", bad, 0);
        count_bad(0, 200, 511, 18'h3FFFF, bad);
        check("partial_kept", bad, 0);

        // Instance b: DEPTH=300 with automatic clear on reset release.
        check("b_rst_busy", b.clr_busy, 0);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_auto_busy", b.clr_busy, 1);
        sweep_b(busy_n, done_n, to);
        check("b_auto_timeout", to, 0);
        check("b_auto_busy_cycles", busy_n, 300);
        check("b_auto_done_pulses", done_n, 1);

        wr(1, 9'd144, 18'h0ABCD);
        wr(1, 9'd299, 18'h1FFFF);
        wr(1, 9'd400, 18'h12345);
        rd(1, 9'd400, d);
        check("b_oor_read", d, 18'h0);
        rd(1, 9'd144, d);
        check("b_no_wrap_144", d, 18'h0ABCD);
        rd(1, 9'd299, d);
        check("b_last_word", d, 18'h1FFFF);
        check("b_oor_wr_dout", b.wr_dout, 18'h0);

        // Reset at sweep cycle 50 restarts a complete sweep from address 0.
        pulse_start(1);
        repeat (50) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_rst_abort_busy", b.clr_busy, 0);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_restart_busy", b.clr_busy, 1);
        sweep_b(busy_n, done_n, to);
        check("b_restart_timeout", to, 0);
        check("b_restart_busy_cycles", busy_n, 300);
        check("b_restart_done_pulses", done_n, 1);
        count_bad(1, 0, 299, 18'h0, bad);
        check("b_restart_all_zero", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
